// File: rtl/serial_subtractor_4bit.sv
// serial_subtractor_4bit: bit-serial a - b (a + ~b + 1) using one full-adder slice, LSB first
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, diff_q, diff_d;
    logic             c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             nb, sum, c_next, last;
    // Next state: operands rotate so the captured MSBs sit at bit 0 on the final step
    always_comb begin
        nb      = ~b_q[0];
        sum     = a_q[0] ^ nb ^ c_q;
        c_next  = (a_q[0] & nb) | (a_q[0] & c_q) | (nb & c_q);
        last    = cnt_q == CW'(WIDTH - 1);
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = a;
                b_d     = b;
                c_d     = 1'b1;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                a_d   = {a_q[0], a_q[WIDTH-1:1]};
                b_d   = {b_q[0], b_q[WIDTH-1:1]};
                r_d   = {sum, r_q[WIDTH-1:1]};
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    diff_d  = r_d;
                    cout_d  = c_next;
                    ovf_d   = (a_q[0] != b_q[0]) && (sum != a_q[0]);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
    assign diff     = diff_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// tb_serial_subtractor_4bit: directed scoreboard bench for the serial subtractor
module tb_serial_subtractor_4bit;
    typedef struct packed {
        logic [3:0] d;
        logic       c;
        logic       v;
    } exp_t;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic [3:0] diff;
    logic       carryout, overflow, busy, done;
    int         checks = 0;
    int         errors = 0;
    int         dn_cnt = 0;
    int         bz_cnt = 0;
    exp_t       sb[$];

    serial_subtractor_4bit #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .diff(diff), .carryout(carryout), .overflow(overflow), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        e.d = x - y;
        e.c = x >= y;
        e.v = (x[3] != y[3]) && (e.d[3] != x[3]);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // one clock; sample at the falling edge and score any completed result
    task automatic step();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        if (busy) bz_cnt++;
        if (done) begin
            dn_cnt++;
            chk("sb_nonempty", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("carryout", 32'(carryout), 32'(e.c));
                chk("overflow", 32'(overflow), 32'(e.v));
            end
        end
    endtask

    task automatic op(input logic [3:0] x, input logic [3:0] y);
        int lat;
        int d0;
        a = x;
        b = y;
        start = 1'b1;
        sb.push_back(model(x, y));
        d0 = dn_cnt;
        step();
        lat = 1;
        start = 1'b0;
        while (dn_cnt == d0 && lat < 12) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 5);
        step();
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int d0;
        int bz0;
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_diff", 32'(diff), 0);
        chk("rst_carry", 32'(carryout), 0);
        chk("rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        op(4'd5, 4'd3);
        op(4'd3, 4'd5);
        op(4'b1000, 4'd1);
        op(4'd7, 4'b1111);
        // start re-asserted and operands changed while running must be ignored
        a = 4'd6;
        b = 4'd2;
        start = 1'b1;
        sb.push_back(model(4'd6, 4'd2));
        d0 = dn_cnt;
        bz0 = bz_cnt;
        step();
        a = 4'd1;
        b = 4'd1;
        step();
        step();
        a = 4'hf;
        b = 4'h3;
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("one_done", 32'(dn_cnt - d0), 1);
        chk("busy_cycles", 32'(bz_cnt - bz0), 5);
        // asynchronous reset two edges into RUN aborts and zeroes results
        a = 4'd12;
        b = 4'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_diff", 32'(diff), 0);
        chk("abort_carry", 32'(carryout), 0);
        chk("abort_ovf", 32'(overflow), 0);
        d0 = dn_cnt;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("no_done_after_abort", 32'(dn_cnt - d0), 0);
        op(4'd9, 4'd9);
        chk("sb_drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
